canvas_buffer: RTL and testbench
================================

Name: canvas_buffer

Overview:
Stores the 32x32 one-bit drawing canvas written by the mouse drawing stage. Provides a registered pixel read port for the VGA overlay. Provides a row-streaming dump port with valid/ready handshake for the recognition stage, and reports the bounding box of the set pixels. After a completed dump it can issue the one-cycle clear request that the drawing stage uses to wipe the canvas.

Parameters:
CLEAR_AFTER_DUMP, 1, when 1 pulse ready_to_clear_canvas after every completed dump; when 0 never assert it.

Ports:
clk  in  1  clock
rst  in  1  reset
wr_en  in  1  canvas write strobe from drawing stage
wr_addr  in  10  {row[4:0], col[4:0]}
wr_data  in  1  pixel value to write
vga_addr  in  10  {row[4:0], col[4:0]} pixel read address
vga_pixel  out  1  pixel at vga_addr, 1-cycle latency
dump_req  in  1  start a full-canvas dump (level or pulse)
row_valid  out  1  row_data/row_idx hold a row
row_ready  in  1  consumer accepts the row
row_data  out  32  row contents, bit c = column c
row_idx  out  5  index of the presented row
busy  out  1  dump in progress
dump_done  out  1  one-cycle pulse after the last row is accepted
bbox_empty  out  1  last dump found no set pixel
bbox_row_min, bbox_row_max, bbox_col_min, bbox_col_max  out  5 each  bounding box of the last dump
ready_to_clear_canvas  out  1  one-cycle clear request to the drawing stage

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. Reset clears all 1024 canvas bits and forces the FSM to IDLE. All outputs are 0 after reset, bbox_empty is 1, and any dump in flight is aborted with no dump_done.
- Storage: 32 rows x 32 bits in flops.
  - When wr_en is high, set canvas[wr_addr[9:5]][wr_addr[4:0]] <= wr_data at the clock edge.
  - Writes are accepted in every state, including during a dump.
- VGA port: vga_pixel <= canvas[vga_addr[9:5]][vga_addr[4:0]] on every cycle.
  - A read and a write to the same address in the same cycle return the old value.
- FSM states: IDLE, DUMP, DONE, CLEAR.
  - IDLE: busy=0. If dump_req is high, load row 0 into row_data, set row_idx=0, row_valid=1, busy=1, clear the bbox accumulators, and go to DUMP. row_valid is therefore first high on the cycle after dump_req.
  - DUMP: row_data and row_idx must not change while row_valid && !row_ready. A write to the presented row after it is loaded does not alter row_data.
  - DUMP, on row_valid && row_ready:
    - Fold row_data into the bbox. A non-zero row updates row_min (first such row) and row_max (last such row). Col_min is the lowest set bit across all rows; col_max is the highest.
    - If row_idx < 31, load row row_idx+1 in the same edge, keeping row_valid high so there is no bubble; back-to-back acceptance gives 1 row per cycle.
    - If row_idx == 31, drop row_valid and go to DONE.
  - DONE (1 cycle):
    - Drive dump_done=1.
    - Latch the bbox outputs. bbox_empty=1 if no bit was set, in which case the min/max outputs are 0.
    - Go to CLEAR if CLEAR_AFTER_DUMP=1, otherwise go to IDLE.
  - CLEAR (1 cycle): drive ready_to_clear_canvas=1, busy=1, then go to IDLE. The block itself does not zero the canvas; the drawing stage performs the clear through the write port.
- dump_req is ignored when the FSM is not in IDLE. A held dump_req restarts a new dump in the first IDLE cycle.
- The bbox outputs hold their value until the next DONE.
- Dump latency with row_ready tied high: dump_req at cycle N gives rows at N+1..N+32, dump_done at N+33, and ready_to_clear_canvas at N+34.

Test Plan:
- Write (row 3, col 7)=1 then read vga_addr=0x067 -> vga_pixel=1 one cycle later; vga_addr=0x068 -> 0; same-cycle write of 0 to 0x067 while reading 0x067 -> still 1, then 0 on the next read.
- Set pixels (2,5) and (20,30); dump with row_ready=1 -> 32 consecutive valid cycles; row_idx 2 gives row_data=0x00000020, row 20 gives 0x40000000; dump_done at N+33; bbox rows 2..20, cols 5..30, bbox_empty=0; ready_to_clear_canvas pulse at N+34.
- Empty canvas dump -> all row_data=0, bbox_empty=1, all bbox fields 0.
- Backpressure: row_ready low for 5 cycles on row 4, with a write of 1 to (4,0) during the stall -> row_data for row 4 stays constant, row_idx stays 4, no row is skipped; the next dump shows bit 0 of row 4 set.
- dump_req pulse during DUMP -> ignored, exactly 32 rows and one dump_done. CLEAR_AFTER_DUMP=0 -> ready_to_clear_canvas never asserted.
- rst asserted at row 10 of a dump -> next cycle row_valid=0, busy=0, no dump_done, canvas all zero, bbox_empty=1.

Source files
------------

// File: rtl/canvas_buffer.sv
// 32x32 one-bit drawing canvas. It has a registered VGA read port, a row-streaming
// dump port with a valid/ready handshake, bounding-box extraction over the dumped
// rows, and an optional one-cycle clear request after each completed dump.
module canvas_buffer #(
   parameter int unsigned CLEAR_AFTER_DUMP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [9:0]  wr_addr,
   input  logic        wr_data,
   input  logic [9:0]  vga_addr,
   output logic        vga_pixel,
   input  logic        dump_req,
   output logic        row_valid,
   input  logic        row_ready,
   output logic [31:0] row_data,
   output logic [4:0]  row_idx,
   output logic        busy,
   output logic        dump_done,
   output logic        bbox_empty,
   output logic [4:0]  bbox_row_min,
   output logic [4:0]  bbox_row_max,
   output logic [4:0]  bbox_col_min,
   output logic [4:0]  bbox_col_max,
   output logic        ready_to_clear_canvas
);

   typedef enum logic [1:0] {StIdle, StDump, StDone, StClear} state_e;

   state_e      state_q, state_d;
   logic [31:0] canvas_q [32];
   logic [31:0] canvas_d [32];
   logic        vga_pixel_q, vga_pixel_d;
   logic        row_valid_q, row_valid_d;
   logic [31:0] row_data_q, row_data_d;
   logic [4:0]  row_idx_q, row_idx_d;

   // Bounding-box accumulators, valid only while a dump is in flight
   logic        acc_any_q, acc_any_d;
   logic [4:0]  acc_row_min_q, acc_row_min_d;
   logic [4:0]  acc_row_max_q, acc_row_max_d;
   logic [31:0] acc_col_or_q, acc_col_or_d;

   logic        bbox_empty_q, bbox_empty_d;
   logic [4:0]  bbox_row_min_q, bbox_row_min_d;
   logic [4:0]  bbox_row_max_q, bbox_row_max_d;
   logic [4:0]  bbox_col_min_q, bbox_col_min_d;
   logic [4:0]  bbox_col_max_q, bbox_col_max_d;

   logic [4:0]  row_next;
   logic        fold_nz;
   logic        fold_any;
   logic [4:0]  fold_row_min;
   logic [4:0]  fold_row_max;
   logic [31:0] fold_col_or;
   logic [4:0]  fold_col_lo;
   logic [4:0]  fold_col_hi;

   // Canvas write port; writes land in every FSM state
   always_comb begin
      for (int r = 0; r < 32; r++) begin
         canvas_d[r] = canvas_q[r];
      end
      if (wr_en) begin
         canvas_d[wr_addr[9:5]][wr_addr[4:0]] = wr_data;
      end
   end

   // VGA read samples the pre-write canvas, so same-address read/write returns old data
   always_comb begin
      vga_pixel_d = canvas_q[vga_addr[9:5]][vga_addr[4:0]];
   end

   // Presented row folded into the running bounding box
   always_comb begin
      row_next     = row_idx_q + 5'd1;
      fold_nz      = (row_data_q != 32'd0);
      fold_any     = acc_any_q | fold_nz;
      fold_row_min = acc_any_q ? acc_row_min_q : row_idx_q;
      fold_row_max = fold_nz ? row_idx_q : acc_row_max_q;
      fold_col_or  = acc_col_or_q | row_data_q;
      fold_col_lo  = 5'd0;
      fold_col_hi  = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (fold_col_or[i]) fold_col_lo = 5'(i);
      end
      for (int i = 0; i < 32; i++) begin
         if (fold_col_or[i]) fold_col_hi = 5'(i);
      end
   end

   // Dump FSM: next state, row streaming and bbox latching
   always_comb begin
      state_d        = state_q;
      row_valid_d    = row_valid_q;
      row_data_d     = row_data_q;
      row_idx_d      = row_idx_q;
      acc_any_d      = acc_any_q;
      acc_row_min_d  = acc_row_min_q;
      acc_row_max_d  = acc_row_max_q;
      acc_col_or_d   = acc_col_or_q;
      bbox_empty_d   = bbox_empty_q;
      bbox_row_min_d = bbox_row_min_q;
      bbox_row_max_d = bbox_row_max_q;
      bbox_col_min_d = bbox_col_min_q;
      bbox_col_max_d = bbox_col_max_q;
      case (state_q)
         StIdle: begin
            if (dump_req) begin
               row_data_d    = canvas_q[0];
               row_idx_d     = 5'd0;
               row_valid_d   = 1'b1;
               acc_any_d     = 1'b0;
               acc_row_min_d = 5'd0;
               acc_row_max_d = 5'd0;
               acc_col_or_d  = 32'd0;
               state_d       = StDump;
            end
         end
         StDump: begin
            if (row_valid_q && row_ready) begin
               acc_any_d     = fold_any;
               acc_row_min_d = fold_row_min;
               acc_row_max_d = fold_row_max;
               acc_col_or_d  = fold_col_or;
               if (row_idx_q != 5'd31) begin
                  row_idx_d  = row_next;
                  row_data_d = canvas_q[row_next];
               end else begin
                  row_valid_d = 1'b0;
                  state_d     = StDone;
                  // Latched on entry so the box is already stable while dump_done is high
                  bbox_empty_d   = ~fold_any;
                  bbox_row_min_d = fold_any ? fold_row_min : 5'd0;
                  bbox_row_max_d = fold_any ? fold_row_max : 5'd0;
                  bbox_col_min_d = fold_any ? fold_col_lo : 5'd0;
                  bbox_col_max_d = fold_any ? fold_col_hi : 5'd0;
               end
            end
         end
         StDone: begin
            state_d = (CLEAR_AFTER_DUMP != 0) ? StClear : StIdle;
         end
         StClear: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         for (int r = 0; r < 32; r++) begin
            canvas_q[r] <= 32'd0;
         end
         vga_pixel_q    <= 1'b0;
         row_valid_q    <= 1'b0;
         row_data_q     <= 32'd0;
         row_idx_q      <= 5'd0;
         acc_any_q      <= 1'b0;
         acc_row_min_q  <= 5'd0;
         acc_row_max_q  <= 5'd0;
         acc_col_or_q   <= 32'd0;
         bbox_empty_q   <= 1'b1;
         bbox_row_min_q <= 5'd0;
         bbox_row_max_q <= 5'd0;
         bbox_col_min_q <= 5'd0;
         bbox_col_max_q <= 5'd0;
      end else begin
         state_q        <= state_d;
         for (int r = 0; r < 32; r++) begin
            canvas_q[r] <= canvas_d[r];
         end
         vga_pixel_q    <= vga_pixel_d;
         row_valid_q    <= row_valid_d;
         row_data_q     <= row_data_d;
         row_idx_q      <= row_idx_d;
         acc_any_q      <= acc_any_d;
         acc_row_min_q  <= acc_row_min_d;
         acc_row_max_q  <= acc_row_max_d;
         acc_col_or_q   <= acc_col_or_d;
         bbox_empty_q   <= bbox_empty_d;
         bbox_row_min_q <= bbox_row_min_d;
         bbox_row_max_q <= bbox_row_max_d;
         bbox_col_min_q <= bbox_col_min_d;
         bbox_col_max_q <= bbox_col_max_d;
      end
   end

   // Outputs
   always_comb begin
      vga_pixel             = vga_pixel_q;
      row_valid             = row_valid_q;
      row_data              = row_data_q;
      row_idx               = row_idx_q;
      busy                  = (state_q != StIdle);
      dump_done             = (state_q == StDone);
      ready_to_clear_canvas = (state_q == StClear);
      bbox_empty            = bbox_empty_q;
      bbox_row_min          = bbox_row_min_q;
      bbox_row_max          = bbox_row_max_q;
      bbox_col_min          = bbox_col_min_q;
      bbox_col_max          = bbox_col_max_q;
   end

endmodule

// File: tb/tb_canvas_buffer.sv
// Bench for canvas_buffer: a table of VGA read/write vectors, then directed dump
// sequences covering backpressure, ignored requests and reset mid-dump. A second
// instance built with CLEAR_AFTER_DUMP=0 sees the same stimulus.
module tb_canvas_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, wr_en, wr_data, dump_req, row_ready;
   logic [9:0]  wr_addr, vga_addr;

   logic        vga_pixel_a, row_valid_a, busy_a, dump_done_a, bbox_empty_a, rtc_a;
   logic [31:0] row_data_a;
   logic [4:0]  row_idx_a, rmin_a, rmax_a, cmin_a, cmax_a;

   logic        vga_pixel_b, row_valid_b, busy_b, dump_done_b, bbox_empty_b, rtc_b;
   logic [31:0] row_data_b;
   logic [4:0]  row_idx_b, rmin_b, rmax_b, cmin_b, cmax_b;

   canvas_buffer #(.CLEAR_AFTER_DUMP(1)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .vga_addr(vga_addr), .vga_pixel(vga_pixel_a), .dump_req(dump_req),
      .row_valid(row_valid_a), .row_ready(row_ready), .row_data(row_data_a),
      .row_idx(row_idx_a), .busy(busy_a), .dump_done(dump_done_a),
      .bbox_empty(bbox_empty_a), .bbox_row_min(rmin_a), .bbox_row_max(rmax_a),
      .bbox_col_min(cmin_a), .bbox_col_max(cmax_a), .ready_to_clear_canvas(rtc_a)
   );

   canvas_buffer #(.CLEAR_AFTER_DUMP(0)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .vga_addr(vga_addr), .vga_pixel(vga_pixel_b), .dump_req(dump_req),
      .row_valid(row_valid_b), .row_ready(row_ready), .row_data(row_data_b),
      .row_idx(row_idx_b), .busy(busy_b), .dump_done(dump_done_b),
      .bbox_empty(bbox_empty_b), .bbox_row_min(rmin_b), .bbox_row_max(rmax_b),
      .bbox_col_min(cmin_b), .bbox_col_max(cmax_b), .ready_to_clear_canvas(rtc_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse counters for the no-clear instance
   int clr_b_cnt  = 0;
   int done_b_cnt = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (rtc_b) clr_b_cnt++;
         if (dump_done_b) done_b_cnt++;
      end
   end

   task automatic wr_pix(input logic [4:0] r, input logic [4:0] c, input logic v);
      wr_en   = 1'b1;
      wr_addr = {r, c};
      wr_data = v;
      tick();
      wr_en   = 1'b0;
   endtask

   logic [31:0] got_rows [32];
   int rows_seen, done_cyc, clr_cyc, done_cnt, clr_cnt;

   // Run one dump; optionally stall on one row (writing bit 0 of it during the stall)
   // and pulse dump_req again at a given cycle. Cycles are counted from the dump_req edge.
   task automatic run_dump(input int stall_row, input int stall_len, input int req_again_at);
      int stall_cnt = 0;
      int exp_idx   = 0;
      logic [31:0] held = 32'd0;
      rows_seen = 0; done_cyc = -1; clr_cyc = -1; done_cnt = 0; clr_cnt = 0;
      for (int r = 0; r < 32; r++) got_rows[r] = 32'hDEAD_BEEF;
      row_ready = 1'b1;
      dump_req  = 1'b1;
      tick();
      dump_req = 1'b0;
      for (int cyc = 1; cyc <= 38 + stall_len; cyc++) begin
         row_ready = 1'b1;
         wr_en     = 1'b0;
         dump_req  = (cyc == req_again_at);
         if (dump_done_a) begin done_cnt++; done_cyc = cyc; end
         if (rtc_a) begin clr_cnt++; clr_cyc = cyc; end
         if (row_valid_a) begin
            if (32'(row_idx_a) == stall_row && stall_cnt < stall_len) begin
               row_ready = 1'b0;
               if (stall_cnt == 0) begin
                  held    = row_data_a;
                  wr_en   = 1'b1;
                  wr_addr = {5'(stall_row), 5'd0};
                  wr_data = 1'b1;
               end else begin
                  check("stall_row_data", row_data_a, held);
                  check("stall_row_idx", 32'(row_idx_a), stall_row);
               end
               stall_cnt++;
            end else begin
               check($sformatf("row_order@%0d", cyc), 32'(row_idx_a), exp_idx);
               got_rows[row_idx_a] = row_data_a;
               exp_idx++;
               rows_seen++;
            end
         end
         tick();
      end
      dump_req  = 1'b0;
      wr_en     = 1'b0;
      check("rows_seen", rows_seen, 32);
      check("dump_done_count", done_cnt, 1);
      check("dump_done_cycle", done_cyc, 33 + stall_len);
      check("clear_count", clr_cnt, 1);
      check("clear_cycle", clr_cyc, 34 + stall_len);
      check("busy_after_dump", 32'(busy_a), 0);
   endtask

   task automatic check_bbox(input string tag, input logic e, input logic [4:0] r0,
                             input logic [4:0] r1, input logic [4:0] c0, input logic [4:0] c1);
      check({tag, "_bbox_empty"}, 32'(bbox_empty_a), 32'(e));
      check({tag, "_bbox_row_min"}, 32'(rmin_a), 32'(r0));
      check({tag, "_bbox_row_max"}, 32'(rmax_a), 32'(r1));
      check({tag, "_bbox_col_min"}, 32'(cmin_a), 32'(c0));
      check({tag, "_bbox_col_max"}, 32'(cmax_a), 32'(c1));
   endtask

   // Expected rows for the (2,5)/(20,30) canvas, optionally with (4,0) set
   function automatic logic [31:0] exp_row(input int r, input bit row4_bit0);
      if (r == 2) return 32'h0000_0020;
      if (r == 20) return 32'h4000_0000;
      if (r == 4 && row4_bit0) return 32'h0000_0001;
      return 32'd0;
   endfunction

   typedef struct {
      logic       we;
      logic [9:0] wa;
      logic       wd;
      logic [9:0] ra;
      logic       exp_pix;
   } vga_vec_t;

   vga_vec_t vecs [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 10'h067, 1'b1, 10'h067, 1'b0};  // old value on same-cycle write
      vecs[1] = '{1'b0, 10'h000, 1'b0, 10'h067, 1'b1};
      vecs[2] = '{1'b0, 10'h000, 1'b0, 10'h068, 1'b0};
      vecs[3] = '{1'b1, 10'h067, 1'b0, 10'h067, 1'b1};  // still old 1
      vecs[4] = '{1'b0, 10'h000, 1'b0, 10'h067, 1'b0};
      vecs[5] = '{1'b1, 10'h3FF, 1'b1, 10'h000, 1'b0};
      vecs[6] = '{1'b0, 10'h000, 1'b0, 10'h3FF, 1'b1};
      vecs[7] = '{1'b1, 10'h3FF, 1'b0, 10'h3FE, 1'b0};

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0; vga_addr = '0;
      dump_req = 1'b0; row_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_row_valid", 32'(row_valid_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_dump_done", 32'(dump_done_a), 0);
      check("rst_clear", 32'(rtc_a), 0);
      check("rst_vga_pixel", 32'(vga_pixel_a), 0);
      check("rst_row_data", row_data_a, 0);
      check_bbox("rst", 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);

      // VGA read/write vectors
      for (int i = 0; i < 8; i++) begin
         wr_en    = vecs[i].we;
         wr_addr  = vecs[i].wa;
         wr_data  = vecs[i].wd;
         vga_addr = vecs[i].ra;
         tick();
         check($sformatf("vga_vec%0d", i), 32'(vga_pixel_a), 32'(vecs[i].exp_pix));
      end
      wr_en = 1'b0;

      // Empty canvas dump
      run_dump(-1, 0, 0);
      for (int r = 0; r < 32; r++) check($sformatf("empty_row%0d", r), got_rows[r], 0);
      check_bbox("empty", 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);

      // Two pixels
      wr_pix(5'd2, 5'd5, 1'b1);
      wr_pix(5'd20, 5'd30, 1'b1);
      run_dump(-1, 0, 0);
      for (int r = 0; r < 32; r++) check($sformatf("two_row%0d", r), got_rows[r], exp_row(r, 0));
      check_bbox("two", 1'b0, 5'd2, 5'd20, 5'd5, 5'd30);
      check("noclear_bbox_row_max", 32'(rmax_b), 20);

      // Backpressure on row 4 with a write into row 4 during the stall
      run_dump(4, 5, 0);
      for (int r = 0; r < 32; r++) check($sformatf("stall_row%0d", r), got_rows[r], exp_row(r, 0));
      check_bbox("stall", 1'b0, 5'd2, 5'd20, 5'd5, 5'd30);
      run_dump(-1, 0, 0);
      for (int r = 0; r < 32; r++) check($sformatf("after_row%0d", r), got_rows[r], exp_row(r, 1));
      check_bbox("after", 1'b0, 5'd2, 5'd20, 5'd0, 5'd30);

      // Request pulse during DUMP is ignored
      run_dump(-1, 0, 10);
      check_bbox("ignreq", 1'b0, 5'd2, 5'd20, 5'd0, 5'd30);

      // Reset in the middle of a dump
      row_ready = 1'b1;
      dump_req  = 1'b1;
      tick();
      dump_req = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (row_valid_a && row_idx_a == 5'd10) break;
         tick();
      end
      check("midrst_reached_row10", 32'(row_idx_a), 10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_row_valid", 32'(row_valid_a), 0);
      check("midrst_busy", 32'(busy_a), 0);
      check("midrst_bbox_empty", 32'(bbox_empty_a), 1);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (dump_done_a) done_cnt++;
         tick();
      end
      check("midrst_no_done", done_cnt, 0);
      run_dump(-1, 0, 0);
      for (int r = 0; r < 32; r++) check($sformatf("midrst_row%0d", r), got_rows[r], 0);
      check_bbox("midrst", 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);

      // No-clear instance: same completed dumps, never a clear request
      tick();
      check("noclear_clear_count", clr_b_cnt, 0);
      check("noclear_done_count", done_b_cnt, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
